// File: rtl/afe_rx_deint.sv
`default_nettype none
// ============================================================================
// Module   : afe_rx_deint
// Brief    : Receive AFE front end. Captures the ADC's time-multiplexed I/Q
//            bus, tracks sel alignment with a hunt/lock FSM, assembles {I,Q}
//            pairs and writes them to the RX FIFO on a half-rate FIFO clock.
//            Pairs dropped on FIFO full are counted (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module afe_rx_deint #(
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int LOCK_PAIRS    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       rx_sclk_2x,
  input  logic                       reset_n,
  input  logic                       sel,
  input  logic [IQ_PAIR_WIDTH/2-1:0] d,
  input  logic                       fifo_full,
  output logic                       clk_2x,
  output logic                       fifo_clk,
  output logic [IQ_PAIR_WIDTH-1:0]   fifo_data,
  output logic                       fifo_wr,
  output logic                       locked,
  output logic                       sel_err,
  output logic [CNT_WIDTH-1:0]       overflow_cnt
);

  localparam int         HALF      = IQ_PAIR_WIDTH / 2;
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_PAIRS - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                   state;
  logic [HALF-1:0]          d_r;
  logic                     sel_r;
  logic                     v_r;        // d_r/sel_r hold a real captured sample
  logic                     sel_prev;   // sel_r one sample earlier
  logic                     v_prev;
  logic [HALF-1:0]          i_hold;
  logic                     i_valid;
  logic [IQ_PAIR_WIDTH-1:0] pair_hold;
  logic                     pair_pend;
  logic [3:0]               lock_cnt;

  logic                     in_lock;
  logic                     viol;
  logic                     lock_viol;
  logic                     form;
  logic                     bypass;
  logic                     slot;
  logic                     wr_cand;
  logic [IQ_PAIR_WIDTH-1:0] pair_new;

  // ADC clock is forwarded untouched, even while in reset.
  assign clk_2x    = rx_sclk_2x;
  assign locked    = (state == LOCKED);

  assign in_lock   = (state == LOCKED);
  assign viol      = v_r & v_prev & (sel_r == sel_prev);
  assign lock_viol = in_lock & viol;
  assign form      = v_r & ~sel_r & i_valid;
  // A pair forming while locked is eligible for writing; a violation kills it.
  assign bypass    = form & in_lock & ~viol;
  // The edge on which fifo_clk falls 1->0 is the write slot.
  assign slot      = fifo_clk;
  assign wr_cand   = slot & (pair_pend | bypass);
  assign pair_new  = {i_hold, d_r};

  // Input stage: register the ADC bus and remember the previous sel.
  always_ff @(posedge rx_sclk_2x or negedge reset_n) begin
    if (!reset_n) begin
      d_r      <= '0;
      sel_r    <= 1'b0;
      v_r      <= 1'b0;
      sel_prev <= 1'b0;
      v_prev   <= 1'b0;
    end else begin
      d_r      <= d;
      sel_r    <= sel;
      v_r      <= 1'b1;
      sel_prev <= sel_r;
      v_prev   <= v_r;
    end
  end

  // Hunt/lock FSM, pair assembly, write slot and overflow counting.
  always_ff @(posedge rx_sclk_2x or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HUNT;
      lock_cnt     <= '0;
      i_hold       <= '0;
      i_valid      <= 1'b0;
      pair_hold    <= '0;
      pair_pend    <= 1'b0;
      fifo_clk     <= 1'b0;
      fifo_data    <= '0;
      fifo_wr      <= 1'b0;
      sel_err      <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      fifo_clk <= ~fifo_clk;
      sel_err  <= lock_viol;

      // Lock tracking: the pair that completes lock is consumed, not written.
      if (state == HUNT) begin
        if (viol) begin
          lock_cnt <= '0;
        end else if (form) begin
          if (lock_cnt == LOCK_LAST) begin
            state    <= LOCKED;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 4'd1;
          end
        end
      end else if (viol) begin
        state    <= HUNT;
        lock_cnt <= '0;
      end

      // I half: an alignment loss while locked discards the partial pair.
      if (lock_viol) begin
        i_valid <= 1'b0;
      end else if (v_r && sel_r) begin
        i_hold  <= d_r;
        i_valid <= 1'b1;
      end else if (form) begin
        i_valid <= 1'b0;
      end

      // Pending pair: parked off-slot, consumed on the slot edge.
      if (lock_viol) begin
        pair_pend <= 1'b0;
      end else if (slot) begin
        if (pair_pend && bypass) begin
          pair_hold <= pair_new;
        end else begin
          pair_pend <= 1'b0;
        end
      end else if (bypass) begin
        pair_hold <= pair_new;
        pair_pend <= 1'b1;
      end

      // Write slot: full flag wins over the write, and counts once.
      if (wr_cand) begin
        fifo_data <= pair_pend ? pair_hold : pair_new;
        fifo_wr   <= in_lock & ~fifo_full;
        if (in_lock && fifo_full && !(&overflow_cnt)) begin
          overflow_cnt <= overflow_cnt + CNT_WIDTH'(1);
        end
      end else if (slot) begin
        fifo_wr <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_afe_rx_deint.sv
`default_nettype none
// ============================================================================
// Module   : tb_afe_rx_deint
// Brief    : Scoreboard bench for afe_rx_deint. A sample-level reference
//            model predicts written pairs (with their write slot edge),
//            overflow count, sel_err pulses and lock state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afe_rx_deint;

  localparam int IQW   = 24;
  localparam int HW    = IQW / 2;
  localparam int LOCKN = 4;
  localparam int CW    = 8;   // narrow counter so saturation is reachable quickly
  localparam int OMAX  = (1 << CW) - 1;
  localparam int AMAX  = 4096;

  logic           rx_sclk_2x = 1'b0;
  logic           reset_n    = 1'b1;
  logic           sel        = 1'b0;
  logic [HW-1:0]  d          = '0;
  logic           fifo_full  = 1'b0;
  wire            clk_2x;
  wire            fifo_clk;
  wire  [IQW-1:0] fifo_data;
  wire            fifo_wr;
  wire            locked;
  wire            sel_err;
  wire  [CW-1:0]  overflow_cnt;

  afe_rx_deint #(
    .IQ_PAIR_WIDTH (IQW),
    .LOCK_PAIRS    (LOCKN),
    .CNT_WIDTH     (CW)
  ) dut (
    .rx_sclk_2x   (rx_sclk_2x),
    .reset_n      (reset_n),
    .sel          (sel),
    .d            (d),
    .fifo_full    (fifo_full),
    .clk_2x       (clk_2x),
    .fifo_clk     (fifo_clk),
    .fifo_data    (fifo_data),
    .fifo_wr      (fifo_wr),
    .locked       (locked),
    .sel_err      (sel_err),
    .overflow_cnt (overflow_cnt)
  );

  always #5 rx_sclk_2x = ~rx_sclk_2x;

  typedef struct {
    logic [IQW-1:0] data;
    int             slot;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp  = 0;
  int n_fail = 0;

  // stimulus history, indexed by the capture edge number since reset release
  bit            sel_a  [AMAX];
  logic [HW-1:0] d_a    [AMAX];
  bit            full_a [AMAX];
  int            cur;

  // reference model state
  bit            m_locked;
  int            m_cnt;
  bit            m_iv;
  logic [HW-1:0] m_ih;
  bit            m_psel;
  bit            m_hasprev;
  int            m_ovf;
  int            m_selerr;

  int mon_selerr = 0;
  int selerr_base;
  int edge_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Sample captured at edge e is acted on at edge e+1; a pair formed there is
  // written on that edge if it is a slot (even edge), otherwise on the next.
  function automatic void model(int e);
    bit            s    = sel_a[e];
    logic [HW-1:0] x    = d_a[e];
    int            dec  = e + 1;
    bit            viol = m_hasprev && (s == m_psel);
    int            slot;
    m_psel    = s;
    m_hasprev = 1'b1;
    if (m_locked && viol) begin
      m_selerr++;
      m_locked = 1'b0;
      m_cnt    = 0;
      m_iv     = 1'b0;
      return;
    end
    if (viol) m_cnt = 0;
    if (s) begin
      m_ih = x;
      m_iv = 1'b1;
    end else if (m_iv) begin
      m_iv = 1'b0;
      if (!m_locked) begin
        m_cnt++;
        if (m_cnt == LOCKN) begin
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end else begin
        slot = (dec % 2 == 0) ? dec : dec + 1;
        if (full_a[slot]) begin
          if (m_ovf < OMAX) m_ovf++;
        end else begin
          exp_q.push_back('{data: {m_ih, x}, slot: slot});
        end
      end
    end
  endfunction

  always @(posedge rx_sclk_2x or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Monitor: a write is new on the negedge right after the slot edge.
  always @(negedge rx_sclk_2x) begin
    if (reset_n) begin
      if (sel_err) mon_selerr++;
      if (fifo_wr && !fifo_clk) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got data=%h, expected no write (t=%0t)", fifo_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_data", 32'(fifo_data), 32'(mon_e.data));
          chk("wr_slot_edge", 32'(edge_cnt), 32'(mon_e.slot));
        end
      end
    end
  end

  task automatic start_epoch();
    cur         = 0;
    m_locked    = 1'b0;
    m_cnt       = 0;
    m_iv        = 1'b0;
    m_ih        = '0;
    m_psel      = 1'b0;
    m_hasprev   = 1'b0;
    m_ovf       = 0;
    m_selerr    = 0;
    selerr_base = mon_selerr;
    exp_q.delete();
  endtask

  task automatic step(bit s, logic [HW-1:0] x, bit f);
    if (cur + 2 >= AMAX) begin
      $display("FAIL stimulus_overrun: got edge %0d, expected below %0d", cur, AMAX);
      $fatal(1);
    end
    sel_a[cur+1]  = s;
    d_a[cur+1]    = x;
    full_a[cur+1] = f;
    sel           = s;
    d             = x;
    fifo_full     = f;
    if (cur >= 2) model(cur - 1);
    @(posedge rx_sclk_2x);
    cur++;
    #1;
  endtask

  task automatic pairs(int n, int base, bit f);
    for (int k = 0; k < n; k++) begin
      step(1'b1, HW'(base + k), f);
      step(1'b0, HW'(12'h800 + base + k), f);
    end
  endtask

  // Orphan-Q tail lets every modelled event settle, then compare totals.
  task automatic checkpoint(string tag);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0);
    @(negedge rx_sclk_2x);
    #1;
    chk({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'(m_ovf));
    chk({tag, "_sel_err_cycles"}, 32'(mon_selerr - selerr_base), 32'(m_selerr));
    chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Clean I=n / Q=0x800+n stream from a fresh reset: lock after 4 pairs.
  task automatic scen_clean(string tag);
    for (int n = 1; n <= 12; n++) begin
      step(1'b1, HW'(n), 1'b0);
      if (n == 5) chk({tag, "_locked_after_4"}, 32'(locked), 32'd1);
      step(1'b0, HW'(12'h800 + n), 1'b0);
      if (n == 4) chk({tag, "_unlocked_at_4"}, 32'(locked), 32'd0);
    end
    checkpoint(tag);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_fifo_clk"}, 32'(fifo_clk), 32'd0);
    chk({tag, "_fifo_data"}, 32'(fifo_data), 32'd0);
    chk({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_sel_err"}, 32'(sel_err), 32'd0);
    chk({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'd0);
    chk({tag, "_clk_2x"}, 32'(clk_2x), 32'(rx_sclk_2x));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    bit rs;
    int ovf_base;

    #2 reset_n = 1'b0;
    #1 check_reset_values("por");
    #5 chk("por_clk_2x_high", 32'(clk_2x), 32'(rx_sclk_2x));
    repeat (2) @(negedge rx_sclk_2x);
    reset_n = 1'b1;
    start_epoch();

    // 1: clean stream
    scen_clean("clean");

    // 2: lock, then an I-I alignment loss
    pairs(6, 8'h20, 1'b0);
    step(1'b1, 12'h0A1, 1'b0);
    step(1'b1, 12'h0A2, 1'b0);
    step(1'b0, 12'h8A2, 1'b0);
    chk("viol_sel_err_pulse", 32'(sel_err), 32'd1);
    chk("viol_locked_drop", 32'(locked), 32'd0);
    step(1'b1, 12'h0B0, 1'b0);
    chk("viol_sel_err_single", 32'(sel_err), 32'd0);
    step(1'b0, 12'h8B0, 1'b0);
    pairs(6, 8'h30, 1'b0);
    checkpoint("viol");

    // 3: ten pair periods of FIFO full while locked
    ovf_base = m_ovf;
    pairs(5, 8'h40, 1'b0);
    for (int j = 0; j < 28; j++) begin
      step((j % 2) == 0, HW'(((j % 2) == 0 ? 12'h050 : 12'h850) + j / 2), (j >= 2) && (j <= 21));
    end
    checkpoint("full10");
    chk("full10_count", 32'(overflow_cnt), 32'(ovf_base + 10));

    // 4: stream starting with an orphan Q
    step(1'b0, 12'h8EE, 1'b0);
    pairs(7, 8'h60, 1'b0);
    checkpoint("orphan");

    // 5: randomized stream with sel glitches and random full
    rs = 1'b0;
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 99) >= 8) rs = ~rs;
      step(rs, HW'($urandom), $urandom_range(0, 99) < 30);
    end
    checkpoint("random");

    // 6: saturate the overflow counter
    pairs(5, 8'h70, 1'b0);
    pairs(270, 0, 1'b1);
    checkpoint("sat");
    chk("sat_all_ones", 32'(overflow_cnt), 32'(OMAX));

    // 7: asynchronous reset mid-pair while locked, then relock
    pairs(6, 8'h90, 1'b0);
    chk("pre_reset_locked", 32'(locked), 32'd1);
    step(1'b1, 12'h099, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    exp_q.delete();
    repeat (2) @(negedge rx_sclk_2x);
    reset_n = 1'b1;
    start_epoch();
    scen_clean("relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
